// File: rtl/tpu_core_param_if.sv
// tpu_core_param_if: weight-load, ifmap and psum handshake bundle for tpu_core_param
interface tpu_core_param_if #(
    parameter int ROWS = 4,
    parameter int COLS = 6,
    parameter int DATA_W = 16,
    parameter int ACC_W = 16
) ();
    logic load_en;
    logic [ROWS*COLS*DATA_W-1:0] weights_in;
    logic in_valid;
    logic in_ready;
    logic [ROWS*DATA_W-1:0] ifmap_in;
    logic out_valid;
    logic out_ready;
    logic [COLS*ACC_W-1:0] psum_out;
    logic busy;
    modport master (
        output load_en, weights_in, in_valid, ifmap_in, out_ready,
        input in_ready, out_valid, psum_out, busy
    );
    modport slave (
        input load_en, weights_in, in_valid, ifmap_in, out_ready,
        output in_ready, out_valid, psum_out, busy
    );
endinterface

// File: rtl/tpu_core_param.sv
// tpu_core_param: weight-stationary systolic matmul core with input skew, output deskew and global stall
module tpu_core_param #(
    parameter int ROWS = 4,
    parameter int COLS = 6,
    parameter int DATA_W = 16,
    parameter int ACC_W = 16
) (
    input logic clk,
    input logic rst,
    tpu_core_param_if.slave bus
);
    localparam int L = ROWS + COLS;
    localparam int CNT_W = $clog2(L + 1);
    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, RUN} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [L-1:0] tag;
    logic stall;
    logic adv;
    logic in_xfer;
    logic out_xfer;
    logic signed [DATA_W-1:0] w [ROWS][COLS];
    logic signed [DATA_W-1:0] x_new [ROWS];
    logic signed [DATA_W-1:0] lane [ROWS];
    logic signed [DATA_W-1:0] a_o [ROWS][COLS];
    logic signed [ACC_W-1:0] p_o [ROWS][COLS];

    assign stall = bus.out_valid && !bus.out_ready;
    assign adv = !stall;
    assign bus.in_ready = state == RUN && !stall;
    assign in_xfer = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;
    assign bus.out_valid = tag[L-1];
    assign bus.busy = !(state == RUN && cnt == '0);

    // Bubble cycles inject zeros so untagged slots never disturb real sums
    always_comb begin
        for (int r = 0; r < ROWS; r++)
            x_new[r] = in_xfer ? bus.ifmap_in[r*DATA_W +: DATA_W] : '0;
    end

    // Control FSM and in-flight counter; a load that coincides with a transfer drains first
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(in_xfer) - CNT_W'(out_xfer);
            case (state)
                IDLE: if (bus.load_en) state <= LOAD;
                RUN: if (bus.load_en) state <= (cnt == '0 && !in_xfer) ? LOAD : DRAIN;
                DRAIN: if (cnt == '0) state <= LOAD;
                default: state <= RUN;
            endcase
        end
    end

    // Stationary weights, captured only in the single LOAD cycle
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!rst) w[r][c] <= '0;
                else if (state == LOAD) w[r][c] <= bus.weights_in[(r*COLS+c)*DATA_W +: DATA_W];
    end

    // Valid tags ride alongside the data for exactly L cycles
    always_ff @(posedge clk) begin
        if (!rst) tag <= '0;
        else if (adv) tag <= {tag[L-2:0], in_xfer};
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_pass
            assign lane[r] = x_new[r];
        end else begin : g_dly
            logic signed [DATA_W-1:0] sk [r];
            // Lane r is delayed r cycles so it meets row r of the array in step
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < r; i++) sk[i] <= '0;
                end else if (adv) begin
                    sk[0] <= x_new[r];
                    for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
                end
            end
            assign lane[r] = sk[r-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [DATA_W-1:0] xin;
            logic signed [DATA_W-1:0] a;
            logic signed [ACC_W-1:0] pin;
            logic signed [ACC_W-1:0] p;
            logic signed [2*DATA_W-1:0] prod;
            if (c == 0) begin : g_left
                assign xin = lane[r];
            end else begin : g_inner
                assign xin = a_o[r][c-1];
            end
            if (r == 0) begin : g_top
                assign pin = '0;
            end else begin : g_below
                assign pin = p_o[r-1][c];
            end
            assign prod = xin * w[r][c];
            assign a_o[r][c] = a;
            assign p_o[r][c] = p;
            // PE: pass ifmap right, accumulate wrapped psum downward
            always_ff @(posedge clk) begin
                if (!rst) begin
                    a <= '0;
                    p <= '0;
                end else if (adv) begin
                    a <= xin;
                    p <= pin + ACC_W'(prod);
                end
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        logic signed [ACC_W-1:0] d [COLS-c];
        // Column c waits COLS-1-c cycles plus a shared output register so all columns align
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < COLS - c; i++) d[i] <= '0;
            end else if (adv) begin
                d[0] <= p_o[ROWS-1][c];
                for (int i = 1; i < COLS - c; i++) d[i] <= d[i-1];
            end
        end
        assign bus.psum_out[c*ACC_W +: ACC_W] = d[COLS-c-1];
    end
endmodule

// File: tb/tb_tpu_core_param.sv
// tb_tpu_core_param: directed self-checking bench for tpu_core_param
module tb_tpu_core_param;
    localparam int ROWS = 4;
    localparam int COLS = 6;
    localparam int DATA_W = 16;
    localparam int ACC_W = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    tpu_core_param_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
    tpu_core_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROWS*COLS*DATA_W-1:0] w_fill(input int mode);
        logic [ROWS*COLS*DATA_W-1:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*DATA_W +: DATA_W] = mode == 0 ? 16'd1 : mode == 1 ? DATA_W'(r + c) : 16'h7FFF;
        return v;
    endfunction

    function automatic logic [ROWS*DATA_W-1:0] x_all(input int k);
        logic [ROWS*DATA_W-1:0] v = '0;
        for (int r = 0; r < ROWS; r++) v[r*DATA_W +: DATA_W] = DATA_W'(k);
        return v;
    endfunction

    function automatic logic [ROWS*DATA_W-1:0] x_ramp();
        logic [ROWS*DATA_W-1:0] v = '0;
        for (int r = 0; r < ROWS; r++) v[r*DATA_W +: DATA_W] = DATA_W'(r + 1);
        return v;
    endfunction

    function automatic logic [COLS*ACC_W-1:0] y_all(input int k);
        logic [COLS*ACC_W-1:0] v = '0;
        for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = ACC_W'(k);
        return v;
    endfunction

    function automatic logic [COLS*ACC_W-1:0] y_ramp(input int k);
        logic [COLS*ACC_W-1:0] v = '0;
        for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = ACC_W'(k * (6 + 4 * c));
        return v;
    endfunction

    initial begin
        bus.load_en = 1'b0;
        bus.weights_in = '0;
        bus.in_valid = 1'b0;
        bus.ifmap_in = '0;
        bus.out_ready = 1'b1;
        ticks(2);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_psum", bus.psum_out, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 1);
        rst = 1'b1;
        ticks(1);
        check("idle_in_ready", bus.in_ready, 0);
        bus.load_en = 1'b1;
        bus.weights_in = w_fill(0);
        ticks(1);
        bus.load_en = 1'b0;
        check("load_in_ready", bus.in_ready, 0);
        ticks(1);
        check("run_in_ready", bus.in_ready, 1);
        check("run_empty_busy", bus.busy, 0);

        bus.in_valid = 1'b1;
        bus.ifmap_in = x_ramp();
        ticks(1);
        bus.in_valid = 1'b0;
        ticks(3);
        check("ones_busy", bus.busy, 1);
        ticks(5);
        check("ones_early", bus.out_valid, 0);
        ticks(1);
        check("ones_valid", bus.out_valid, 1);
        check("ones_psum", bus.psum_out, y_all(10));
        ticks(1);
        check("ones_after", bus.out_valid, 0);
        check("ones_idle_busy", bus.busy, 0);

        bus.load_en = 1'b1;
        bus.weights_in = w_fill(1);
        ticks(1);
        bus.load_en = 1'b0;
        ticks(1);
        for (int k = 1; k <= 8; k++) begin
            bus.in_valid = 1'b1;
            bus.ifmap_in = x_all(k);
            #1;
            check("b2b_in_ready", bus.in_ready, 1);
            ticks(1);
        end
        bus.in_valid = 1'b0;
        ticks(2);
        for (int k = 1; k <= 8; k++) begin
            check("b2b_valid", bus.out_valid, 1);
            check("b2b_psum", bus.psum_out, y_ramp(k));
            ticks(1);
        end
        check("b2b_after", bus.out_valid, 0);

        for (int k = 1; k <= 3; k++) begin
            bus.in_valid = 1'b1;
            bus.ifmap_in = x_all(k);
            ticks(1);
        end
        bus.in_valid = 1'b0;
        ticks(7);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.ifmap_in = x_all(9);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", bus.out_valid, 1);
            check("stall_psum", bus.psum_out, y_ramp(1));
            check("stall_in_ready", bus.in_ready, 0);
            ticks(1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check("stall_drain_valid", bus.out_valid, 1);
            check("stall_drain_psum", bus.psum_out, y_ramp(k));
            ticks(1);
        end
        check("stall_after", bus.out_valid, 0);

        for (int k = 1; k <= 4; k++) begin
            bus.in_valid = 1'b1;
            bus.ifmap_in = x_all(k);
            ticks(1);
        end
        bus.in_valid = 1'b0;
        bus.load_en = 1'b1;
        bus.weights_in = w_fill(0);
        ticks(1);
        check("drain_in_ready", bus.in_ready, 0);
        ticks(2);
        bus.load_en = 1'b0;
        ticks(3);
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", bus.out_valid, 1);
            check("drain_old_psum", bus.psum_out, y_ramp(k));
            ticks(1);
        end
        check("drain_done_valid", bus.out_valid, 0);
        check("drain_last_in_ready", bus.in_ready, 0);
        ticks(1);
        check("reload_in_ready", bus.in_ready, 0);
        check("reload_busy", bus.busy, 1);
        ticks(1);
        check("rerun_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.ifmap_in = x_ramp();
        ticks(1);
        bus.in_valid = 1'b0;
        ticks(9);
        check("new_w_valid", bus.out_valid, 1);
        check("new_w_psum", bus.psum_out, y_all(10));
        ticks(1);

        bus.in_valid = 1'b1;
        bus.ifmap_in = x_ramp();
        bus.load_en = 1'b1;
        bus.weights_in = w_fill(2);
        #1;
        check("same_cycle_in_ready", bus.in_ready, 1);
        ticks(1);
        bus.in_valid = 1'b0;
        bus.load_en = 1'b0;
        check("same_cycle_drain", bus.in_ready, 0);
        ticks(9);
        check("same_cycle_valid", bus.out_valid, 1);
        check("same_cycle_psum", bus.psum_out, y_all(10));
        ticks(1);
        check("same_cycle_wait", bus.in_ready, 0);
        ticks(2);
        check("max_run_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.ifmap_in = x_all(16'h7FFF);
        ticks(1);
        bus.in_valid = 1'b0;
        ticks(9);
        check("max_valid", bus.out_valid, 1);
        check("max_wrap_psum", bus.psum_out, y_all(4));
        ticks(1);

        for (int k = 1; k <= 5; k++) begin
            bus.in_valid = 1'b1;
            bus.ifmap_in = x_all(k);
            ticks(1);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        ticks(1);
        rst = 1'b1;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_psum", bus.psum_out, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_busy", bus.busy, 1);
        bus.in_valid = 1'b1;
        bus.ifmap_in = x_all(5);
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            check("midrst_no_valid", bus.out_valid, 0);
            check("midrst_idle_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.load_en = 1'b1;
        bus.weights_in = w_fill(0);
        ticks(1);
        bus.load_en = 1'b0;
        ticks(1);
        check("midrst_reload_ready", bus.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tpu_core_param.md
TPU_CORE_PARAM -- requirements
Module: tpu_core_param

Interface
REQ-001 Parameter ROWS, default 4, array rows; this is the number of ifmap lanes and weight rows.
REQ-002 Parameter COLS, default 6, array columns; this is the number of psum lanes.
REQ-003 Parameter DATA_W, default 16, width of each signed ifmap element and each signed weight.
REQ-004 Parameter ACC_W, default 16, width of each signed psum element.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port load_en, input, 1 bit: weight-load request.
REQ-008 Port weights_in, input, ROWS*COLS*DATA_W bits: W[r][c] at bits [(r*COLS+c)*DATA_W +: DATA_W].
REQ-009 Port in_valid, input, 1 bit: ifmap_in holds a valid vector.
REQ-010 Port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-011 Port ifmap_in, input, ROWS*DATA_W bits: unskewed vector; x[r] at bits [r*DATA_W +: DATA_W].
REQ-012 Port out_valid, output, 1 bit: psum_out holds a result.
REQ-013 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 Port psum_out, output, COLS*ACC_W bits: column-aligned results; y[c] at bits [c*ACC_W +: ACC_W].
REQ-015 Port busy, output, 1 bit: high in any state except RUN with an empty pipeline.

Function
REQ-016 The block SHALL compute y[c] = sum over r of x[r]*W[r][c], using signed two's-complement arithmetic, with the product and each accumulation truncated to ACC_W bits (wrap, no saturation).
REQ-017 The block SHALL be weight-stationary: weights are latched in LOAD and held constant until the next LOAD.
REQ-018 The internal input skew SHALL delay lane r by r cycles, with zeros injected in the unused slots.
REQ-019 The output deskew SHALL delay column c by COLS-1-c cycles, so that all y[c] of one vector appear in the same cycle.
REQ-020 Fixed latency L = ROWS+COLS cycles: a vector accepted at cycle t SHALL appear with out_valid=1 at cycle t+L, given no stalls.
REQ-021 A valid tag SHALL travel with each vector through a shift register of length L; vectors from bubble cycles (in_valid=0) SHALL never assert out_valid.
REQ-022 Stall: when out_valid=1 and out_ready=0, the whole pipeline, including the skew, array, deskew and tags, SHALL freeze, and psum_out SHALL hold stable.
REQ-023 in_ready SHALL equal (state==RUN) && !stall.
REQ-024 A transfer occurs on in_valid && in_ready; an output transfer occurs on out_valid && out_ready.
REQ-025 An in-flight counter, range 0..L, SHALL increment on an input transfer, decrement on an output transfer, and stay unchanged when both occur in the same cycle.
REQ-026 The FSM SHALL have the states IDLE, DRAIN, LOAD and RUN.
REQ-027 IDLE SHALL be the state after reset; in_ready=0 in IDLE; load_en moves the FSM to LOAD.
REQ-028 In RUN, load_en with the counter at 0 SHALL move the FSM to LOAD; load_en with the counter above 0 SHALL move it to DRAIN.
REQ-029 DRAIN SHALL hold in_ready=0 until the counter reaches 0, then move to LOAD; a pending load SHALL never be dropped.
REQ-030 LOAD SHALL last exactly 1 cycle, capture weights_in, and then move to RUN.
REQ-031 load_en asserted during LOAD or DRAIN SHALL be ignored.
REQ-032 An input transfer and load_en in the same RUN cycle SHALL both take effect: the vector is accepted and then drained under the old weights.
REQ-033 The minimum sustained throughput SHALL be 1 vector per cycle in RUN with out_ready=1.

Reset
REQ-034 On rst=0 at a clock edge, the FSM SHALL go to IDLE and the weights, skew, array, deskew, tags and counter SHALL clear to 0.
REQ-035 After reset, out_valid=0, psum_out=0, in_ready=0 and busy=1.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight vectors, with no out_valid in the cycle after reset.

Verification
REQ-037 Load W[r][c]=1 with all defaults, then send x=[1,2,3,4] at cycle t: out_valid=1 at t+10, with every y[c]=10.
REQ-038 Load W[r][c]=r+c, then send 8 back-to-back vectors, the k-th being x[r]=k: each result is y[c]=k*(6+4c), delivered on 8 consecutive cycles with in_ready steady at 1.
REQ-039 Hold out_ready=0 for 5 cycles while 3 vectors are in flight: psum_out stays stable, in_ready=0, and all 3 results later arrive in order with none lost or duplicated.
REQ-040 Assert load_en with 4 vectors in flight: the FSM goes to DRAIN; the 4 old-weight results arrive first, followed by one LOAD cycle; a next vector returns a new-weight result.
REQ-041 Use x[r]=0x7FFF and W=0x7FFF, all defaults: each y[c] equals the truncated 16-bit sum 4*(0x3FFF0001 mod 2^16) mod 2^16 = 0x0004.
REQ-042 Pull rst=0 for 1 cycle with 5 vectors in flight: out_valid stays 0 afterward, the FSM is in IDLE, and in_ready=0 until the next load_en.
